// File: rtl/sound_pkg.sv
// Shared definitions for the sound recorder session controller.
// Holds the session state encoding, default timing/memory constants and the
// playback midscale helper.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

  localparam int unsigned SAMPLE_INTERVAL_CLK = 6000;
  localparam int unsigned MEMORY_SIZE         = 32768;
  localparam int unsigned DEF_DATA_W          = 10;

  // Silent output level for an unsigned sample of width w.
  function automatic int unsigned midscale_of(input int unsigned w);
    return 32'(1) << (w - 1);
  endfunction

  localparam int unsigned MIDSCALE = midscale_of(DEF_DATA_W);

endpackage

// File: rtl/sound_session_ctrl_button_debouncer.sv
// Button front end: 2-FF synchronizer, debounce counter and press pulse.
// Ports:
//   clk, reset_n_clk : clock, asynchronous active-low reset
//   btn_n_i          : raw active-low button, asynchronous
//   press_o          : one-cycle pulse on a debounced 1->0 transition
module button_debouncer #(
  parameter int unsigned DEBOUNCE_CLK = 1250000
) (
  input  logic clk,
  input  logic reset_n_clk,
  input  logic btn_n_i,
  output logic press_o
);

  localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CLK + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CLK - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Synchronizer, debounced level, stability counter and press pulse.
  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  // Level follows the input only after DEBOUNCE_CLK consecutive differing
  // cycles; any matching cycle restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
      end
    end
    press_d = level_q & ~level_d;
  end

  assign press_o = press_q;

endmodule

// File: rtl/sound_session_ctrl.sv
// Session sequencer for the sound recorder: turns record/play/stop buttons
// into mutually exclusive IDLE/RECORD/PLAY sessions and paces playback.
// Ports:
//   clk, reset_n_clk     : clock, asynchronous active-low reset
//   btn_*_n              : raw active-low buttons (record, play, stop)
//   write_pointer        : recorded sample count from the recorder
//   read_data            : memory read data for read_pointer
//   record_n             : low while recording
//   read_pointer         : playback address
//   sample_out/_valid    : playback sample and its one-cycle update strobe
//   state                : 0=IDLE, 1=RECORD, 2=PLAY
//   mem_full             : write_pointer at its saturation value
module sound_session_ctrl #(
  parameter int unsigned SAMPLE_INTERVAL_CLK = sound_pkg::SAMPLE_INTERVAL_CLK,
  parameter int unsigned MEMORY_SIZE         = sound_pkg::MEMORY_SIZE,
  parameter int unsigned ADDR_W              = 15,
  parameter int unsigned DATA_W              = sound_pkg::DEF_DATA_W,
  parameter int unsigned DEBOUNCE_CLK        = 1250000,
  parameter int unsigned READ_LATENCY        = 2
) (
  input  logic              clk,
  input  logic              reset_n_clk,
  input  logic              btn_record_n,
  input  logic              btn_play_n,
  input  logic              btn_stop_n,
  input  logic [ADDR_W-1:0] write_pointer,
  input  logic [DATA_W-1:0] read_data,
  output logic              record_n,
  output logic [ADDR_W-1:0] read_pointer,
  output logic [DATA_W-1:0] sample_out,
  output logic              sample_valid,
  output logic [1:0]        state,
  output logic              mem_full
);

  import sound_pkg::*;

  localparam int unsigned       TICK_W    = $clog2(SAMPLE_INTERVAL_CLK + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_INTERVAL_CLK - 1);
  localparam logic [DATA_W-1:0] MID       = DATA_W'(midscale_of(DATA_W));
  localparam logic [ADDR_W-1:0] FULL_PTR  = ADDR_W'(MEMORY_SIZE - 1);

  // The pointer is held for a whole sample interval, which must cover the read latency.
  if (READ_LATENCY >= SAMPLE_INTERVAL_CLK) begin : g_bad_latency
    $error("READ_LATENCY must be smaller than SAMPLE_INTERVAL_CLK");
  end

  logic rec_press, play_press, stop_press;

  button_debouncer #(.DEBOUNCE_CLK(DEBOUNCE_CLK)) u_db_record (
    .clk(clk), .reset_n_clk(reset_n_clk), .btn_n_i(btn_record_n), .press_o(rec_press)
  );
  button_debouncer #(.DEBOUNCE_CLK(DEBOUNCE_CLK)) u_db_play (
    .clk(clk), .reset_n_clk(reset_n_clk), .btn_n_i(btn_play_n), .press_o(play_press)
  );
  button_debouncer #(.DEBOUNCE_CLK(DEBOUNCE_CLK)) u_db_stop (
    .clk(clk), .reset_n_clk(reset_n_clk), .btn_n_i(btn_stop_n), .press_o(stop_press)
  );

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   rp_q, rp_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [DATA_W-1:0]   sample_q, sample_d;
  logic                valid_q, valid_d;
  logic                record_n_q, record_n_d;
  logic                full_c;
  logic [ADDR_W-1:0]   last_rp_c;

  // Direct compare so mem_full tracks write_pointer without lag.
  assign full_c    = (write_pointer == FULL_PTR);
  assign last_rp_c = ADDR_W'(write_pointer - 1'b1);

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n_clk) begin
    if (!reset_n_clk) begin
      state_q    <= IDLE;
      rp_q       <= '0;
      tick_q     <= '0;
      sample_q   <= MID;
      valid_q    <= 1'b0;
      record_n_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      rp_q       <= rp_d;
      tick_q     <= tick_d;
      sample_q   <= sample_d;
      valid_q    <= valid_d;
      record_n_q <= record_n_d;
    end
  end

  // Session transitions and playback pacing; one event per cycle, stop > record > play.
  always_comb begin
    state_d  = state_q;
    rp_d     = rp_q;
    tick_d   = tick_q;
    sample_d = sample_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        sample_d = MID;
        rp_d     = '0;
        tick_d   = '0;
        if (stop_press) begin
          state_d = IDLE;
        end else if (rec_press) begin
          if (!full_c) state_d = RECORD;
        end else if (play_press && (write_pointer != '0)) begin
          state_d = PLAY;
        end
      end
      RECORD: begin
        sample_d = MID;
        rp_d     = '0;
        if (stop_press || full_c) state_d = IDLE;
      end
      PLAY: begin
        if (stop_press) begin
          state_d  = IDLE;
          rp_d     = '0;
          tick_d   = '0;
          sample_d = MID;
        end else if (tick_q == TICK_LAST) begin
          // read_pointer has been stable all interval, so read_data is settled.
          sample_d = read_data;
          valid_d  = 1'b1;
          tick_d   = '0;
          if (rp_q == last_rp_c) begin
            state_d = IDLE;
            rp_d    = '0;
          end else begin
            rp_d = ADDR_W'(rp_q + 1'b1);
          end
        end else begin
          tick_d = TICK_W'(tick_q + 1'b1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Follows the next state so record_n and RECORD change in the same cycle.
    record_n_d = (state_d != RECORD);
  end

  assign record_n     = record_n_q;
  assign read_pointer = rp_q;
  assign sample_out   = sample_q;
  assign sample_valid = valid_q;
  assign state        = state_q;
  assign mem_full     = full_c;

endmodule
